// File: rtl/countdown_timer_4bit.sv
// Loadable down-counter/timer with start/pause control and a one-cycle terminal-count pulse.
// With AUTO_RELOAD set, it reloads from the last loaded value on terminal count and becomes a periodic tick.
module countdown_timer_4bit #(
   parameter int WIDTH       = 4,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] reload_val;

   assign busy = (state != IDLE);

   // NOTE: all state uses non-blocking assignments; done is cleared first so any later
   // assignment in the same edge wins, which makes it a clean one-cycle pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count      <= '0;
         reload_val <= '0;
         state      <= IDLE;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            count      <= load_data;
            reload_val <= load_data;
            state      <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (count != '0) state <= RUN;
                     else             done  <= 1'b1;
                  end
               end
               RUN: begin
                  if (pause) begin
                     state <= HOLD;
                  end else if (count > WIDTH'(1)) begin
                     count <= count - WIDTH'(1);
                  end else begin
                     // Terminal count; the count==0 case cannot arise in RUN but is kept safe.
                     done <= 1'b1;
                     if (AUTO_RELOAD) begin
                        count <= reload_val;
                     end else begin
                        count <= '0;
                        state <= IDLE;
                     end
                  end
               end
               HOLD: begin
                  if (!pause) state <= RUN;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_countdown_timer_4bit.sv
// Scoreboard bench: one one-shot and one auto-reload timer share stimulus; a behavioural
// model predicts each edge, and a monitor compares after every rising edge.
module tb_countdown_timer_4bit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_data = '0;
   logic       start = 1'b0;
   logic       pause = 1'b0;

   logic [3:0] count0, count1;
   logic       busy0, busy1, done0, done1;

   int n_cmp = 0;
   int n_bad = 0;

   countdown_timer_4bit #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
      .clk(clk), .reset(reset), .load(load), .load_data(load_data),
      .start(start), .pause(pause), .count(count0), .busy(busy0), .done(done0)
   );

   countdown_timer_4bit #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
      .clk(clk), .reset(reset), .load(load), .load_data(load_data),
      .start(start), .pause(pause), .count(count1), .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;

   // Behavioural view of a timer: remaining ticks, whether it is counting, whether it is frozen.
   typedef struct {
      int cnt;
      int rel;
      bit running;
      bit frozen;
      bit done;
   } mdl_t;

   typedef struct {
      int cnt0; bit busy0; bit done0;
      int cnt1; bit busy1; bit done1;
   } exp_t;

   mdl_t m0, m1;
   exp_t sb[$];

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.cnt = 0; r.rel = 0; r.running = 0; r.frozen = 0; r.done = 0;
      return r;
   endfunction

   function automatic mdl_t step(mdl_t m, bit ar, bit ld, int ldd, bit st, bit ps);
      mdl_t n = m;
      n.done = 0;
      if (ld) begin
         n.cnt = ldd; n.rel = ldd; n.running = 0; n.frozen = 0;
      end else if (!m.running) begin
         if (st) begin
            if (m.cnt == 0) n.done = 1;
            else            n.running = 1;
         end
      end else if (m.frozen) begin
         if (!ps) n.frozen = 0;
      end else if (ps) begin
         n.frozen = 1;
      end else if (m.cnt > 1) begin
         n.cnt = m.cnt - 1;
      end else begin
         n.done = 1;
         if (ar) n.cnt = m.rel;
         else begin
            n.cnt = 0; n.running = 0;
         end
      end
      return n;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t snap();
      exp_t e;
      e.cnt0 = m0.cnt; e.busy0 = m0.running; e.done0 = m0.done;
      e.cnt1 = m1.cnt; e.busy1 = m1.running; e.done1 = m1.done;
      return e;
   endfunction

   // One clock cycle of stimulus: drive in the low phase and predict the next edge.
   task automatic cyc(bit ld, int ldd, bit st, bit ps);
      @(negedge clk);
      load = ld; load_data = 4'(ldd); start = st; pause = ps;
      m0 = step(m0, 1'b0, ld, ldd, st, ps);
      m1 = step(m1, 1'b1, ld, ldd, st, ps);
      sb.push_back(snap());
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   // Asynchronous reset pulse between edges, with an immediate check of the outputs.
   task automatic pulse_reset();
      @(negedge clk);
      load = 0; start = 0; pause = 0; load_data = '0;
      #1 reset = 1'b1;
      #1;
      check("rst_count0", 32'(count0), 0);
      check("rst_busy0",  32'(busy0),  0);
      check("rst_done0",  32'(done0),  0);
      check("rst_count1", 32'(count1), 0);
      check("rst_busy1",  32'(busy1),  0);
      check("rst_done1",  32'(done1),  0);
      #1 reset = 1'b0;
      m0 = step(mdl_reset(), 1'b0, 0, 0, 0, 0);
      m1 = step(mdl_reset(), 1'b1, 0, 0, 0, 0);
      sb.push_back(snap());
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("count0", 32'(count0), 32'(e.cnt0));
            check("busy0",  32'(busy0),  32'(e.busy0));
            check("done0",  32'(done0),  32'(e.done0));
            check("count1", 32'(count1), 32'(e.cnt1));
            check("busy1",  32'(busy1),  32'(e.busy1));
            check("done1",  32'(done1),  32'(e.done1));
         end
      end
   end

   initial begin : stimulus
      int guard;
      m0 = mdl_reset();
      m1 = mdl_reset();
      #2;
      check("init_count0", 32'(count0), 0);
      check("init_busy0",  32'(busy0),  0);
      check("init_done1",  32'(done1),  0);
      pulse_reset();

      // Plain countdown from 5.
      cyc(1, 5, 0, 0);
      cyc(0, 0, 1, 0);
      idle(7);

      // Auto-reload period 15 for three periods (one-shot copy stops at zero).
      cyc(1, 15, 0, 0);
      cyc(0, 0, 1, 0);
      idle(48);

      // Pause for 3 cycles while count is 3.
      cyc(1, 5, 0, 0);
      cyc(0, 0, 1, 0);
      idle(2);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
      idle(8);

      // Start with count 0, then load with a same-cycle start.
      pulse_reset();
      cyc(0, 0, 1, 0);
      idle(2);
      cyc(1, 9, 1, 0);
      idle(4);

      // Reload mid-countdown, then restart.
      cyc(1, 12, 0, 0);
      cyc(0, 0, 1, 0);
      idle(5);
      cyc(1, 3, 0, 0);
      idle(2);
      cyc(0, 0, 1, 0);
      idle(5);

      // Reset in the middle of a countdown.
      cyc(1, 10, 0, 0);
      cyc(0, 0, 1, 0);
      idle(4);
      pulse_reset();
      idle(4);

      // Randomised traffic, with load value 1 and start/pause storms included.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) pulse_reset();
         else cyc(($urandom_range(0, 11) == 0), $urandom_range(0, 15),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      end
      idle(3);

      guard = 0;
      while (sb.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #2;
      check("scoreboard_drained", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/countdown_timer_4bit.md
# countdown_timer_4bit

Loadable down-counter/timer with start/pause control and a terminal-count pulse; the counting-down counterpart to the team's loadable 4-bit up-counter. A value is loaded, `start` launches the countdown, and `done` pulses for one cycle when the count reaches zero. Optional auto-reload turns it into a periodic tick generator for sequencing and timeout logic.

## Interface
- `WIDTH`, 4, counter and load-data width in bits (≥2).
- `AUTO_RELOAD`, 0, 1 = on reaching zero, reload from the last loaded value and keep running; 0 = stop at zero.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `load`  input  1  load `load_data` into count and reload register.
- `load_data`  input  WIDTH  value to load.
- `start`  input  1  begin countdown (honoured in IDLE only).
- `pause`  input  1  freeze countdown while running.
- `count`  output  WIDTH  current count value (registered).
- `busy`  output  1  high in RUN or HOLD.
- `done`  output  1  registered one-cycle pulse on terminal count.

## Operation
- Registers: `count`, `reload_val` (WIDTH), `state`, `done`.
- Reset (async, immediate, no clock needed): `count`=0, `reload_val`=0, `state`=IDLE, `busy`=0, `done`=0.
- `done` defaults to 0 every cycle unless set below.
- Priority per edge: `load` > `start` > `pause` > decrement.
- `load`=1, any state: `count`←`load_data`, `reload_val`←`load_data`, `state`→IDLE, `done`=0; a same-cycle `start` is ignored.
- IDLE:
  - `start`=1, `count`≠0 → RUN; `count` unchanged.
  - `start`=1, `count`=0 → `done`=1 next cycle; stay IDLE.
- RUN:
  - `pause`=1 → HOLD, no decrement.
  - `pause`=0, `count`>1 → `count`←`count`−1.
  - `pause`=0, `count`=1 → `done`←1.
    - `AUTO_RELOAD`=1: `count`←`reload_val`, stay RUN.
    - `AUTO_RELOAD`=0: `count`←0, → IDLE.
- HOLD: `count` frozen.
  - `pause`=0 → RUN; no decrement on this edge.
  - `start` is ignored.
- `start` in RUN/HOLD is ignored.
- `busy` = (`state`≠IDLE), decoded from the state register.
- No wrap below zero; `count` never underflows. The state encoding is free; unused encodings return to IDLE.

## Timing
- `load` at edge k → `count`=`load_data` after edge k.
- `start` at edge k with `count`=N≥1:
  - `busy`=1 after k.
  - `count`=N−1 after k+1, …, 0 after k+N.
  - `done`=1 and `busy`=0 after k+N; `done`=0 after k+N+1.
  - Latency start→done = N cycles.
- Auto-reload with `reload_val`=R: `done` every R cycles. `count` sequence … 2, 1, R, R−1 …; `count` never shows 0 while running. With R=1, `done` is high every cycle.
- A pause burst of P cycles beginning in RUN delays `done` by P+1 cycles (entry edge plus exit edge).
- `reset` mid-operation aborts immediately; any pending `done` is lost.

## Test plan
- Load 5, start → `count` 4, 3, 2, 1, 0 on consecutive edges. `done`=1 exactly on the edge `count`=0; `busy` drops on the same edge.
- `AUTO_RELOAD`=1, load 15, start → `done` pulses every 15 cycles for ≥3 periods. `count` goes 1→15; `busy` stays 1.
- Load 5, start, assert `pause` for 3 cycles when `count`=3 → `count` holds 3 for 4 edges. `done` arrives 4 cycles later than unpaused; `busy` stays 1.
- In IDLE with `count`=0, start → `done`=1 for one cycle and `busy`=0. Then `load`=1 (`load_data`=9) with `start`=1 in the same cycle → `count`=9, state IDLE, no countdown.
- Load 12, start; at `count`=7 assert `load` (`load_data`=3) → `count`=3, `busy`=0, no `done`. A subsequent start → `done` after 3 cycles.
- Load 10, start; at `count`=6 assert `reset` between clock edges → `count`=0, `busy`=0, `done`=0 immediately. After reset release, no activity until load/start.
